// File: rtl/gf_pkg.sv
// Shared GF(p) constants, FSM state type and operand pre-reduction helper.
package gf_pkg;

  localparam int unsigned MODULUS_17 = 17;
  localparam int unsigned OPERAND_W  = 5;
  localparam int unsigned PRODUCT_W  = 9;
  localparam int unsigned ACC_W      = PRODUCT_W + 1;
  localparam int unsigned CNT_W      = $clog2(OPERAND_W + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Single conditional subtract: any 5-bit value lands in 0..16.
  function automatic logic [OPERAND_W-1:0] pre_reduce(input logic [OPERAND_W-1:0] x);
    return (x >= OPERAND_W'(MODULUS_17)) ? x - OPERAND_W'(MODULUS_17) : x;
  endfunction

endpackage

// File: rtl/gf17_serial_mult.sv
// Serial shift-and-add multiplier producing the raw 9-bit product of two
// pre-reduced GF(17) operands, with valid/ready handshakes on both sides.
module gf17_serial_mult
  import gf_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [OPERAND_W-1:0] a,
  input  logic [OPERAND_W-1:0] b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PRODUCT_W-1:0] prod
);

  state_e               state;
  state_e               state_next;
  logic                 in_ready_d;
  logic                 out_valid_d;
  logic [PRODUCT_W-1:0] a_sh;
  logic [OPERAND_W-1:0] b_sh;
  logic [ACC_W-1:0]     acc;
  logic [ACC_W-1:0]     acc_next;
  logic [CNT_W-1:0]     cnt;
  logic                 last_iter;

  assign last_iter = (cnt == CNT_W'(OPERAND_W - 1));
  assign acc_next  = acc + (b_sh[0] ? ACC_W'(a_sh) : ACC_W'(0));

  // Next-state and registered-output decode.
  always_comb begin
    state_next  = state;
    in_ready_d  = 1'b0;
    out_valid_d = 1'b0;
    case (state)
      IDLE: if (in_valid) state_next = MUL;
      MUL:  if (last_iter) state_next = DONE;
      DONE: if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    in_ready_d  = (state_next == IDLE);
    out_valid_d = (state_next == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      prod      <= '0;
      a_sh      <= '0;
      b_sh      <= '0;
      acc       <= '0;
      cnt       <= '0;
    end else begin
      state     <= state_next;
      in_ready  <= in_ready_d;
      out_valid <= out_valid_d;
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh <= PRODUCT_W'(pre_reduce(a));
            b_sh <= pre_reduce(b);
            acc  <= '0;
            cnt  <= '0;
          end
        end
        MUL: begin
          // One multiplier bit per edge; the final add goes straight to prod.
          acc  <= acc_next;
          a_sh <= a_sh << 1;
          b_sh <= b_sh >> 1;
          cnt  <= cnt + CNT_W'(1);
          if (last_iter) prod <= PRODUCT_W'(acc_next);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gf17_serial_mult.sv
// Self-checking bench for gf17_serial_mult: cycle model plus directed vectors.
module tb_gf17_serial_mult;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [4:0] a_i;
  logic [4:0] b_i;
  logic       out_valid;
  logic       out_ready;
  logic [8:0] prod;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  // Reference model: idle flag, edges since accept, expected and held product.
  bit m_idle = 1'b1;
  int m_age = 0;
  int m_prod = 0;
  int m_last = 0;

  gf17_serial_mult dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a_i),
    .b         (b_i),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .prod      (prod)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Compare DUT against the model every cycle, then advance the model across the next edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("mon_in_ready", int'(in_ready), int'(m_idle));
      chk("mon_out_valid", int'(out_valid), int'(!m_idle && m_age >= 5));
      chk("mon_prod", int'(prod), m_last);
    end
    if (!rst_n) begin
      m_idle = 1'b1;
      m_age  = 0;
      m_last = 0;
    end else if (m_idle) begin
      if (in_valid) begin
        m_idle = 1'b0;
        m_age  = 0;
        m_prod = (int'(a_i) % 17) * (int'(b_i) % 17);
      end
    end else if (m_age >= 5) begin
      if (out_ready) m_idle = 1'b1;
    end else begin
      m_age++;
      if (m_age == 5) m_last = m_prod;
    end
  end

  task automatic send(input int av, input int bv);
    bit ok = 1'b0;
    a_i = 5'(av);
    b_i = 5'(bv);
    in_valid = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (!ok) chk("accept_timeout", 0, 1);
  endtask

  task automatic wait_result(output int p, output int lat);
    bit ok = 1'b0;
    p = -1;
    lat = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      lat++;
      if (out_valid && out_ready) begin
        ok = 1'b1;
        p = int'(prod);
      end
    end
    @(posedge clk);
    #1;
    if (!ok) chk("result_timeout", 0, 1);
  endtask

  initial begin
    int p;
    int lat;
    int bad;
    int last_acc;
    int n_res;
    bit ok;

    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    a_i = '0;
    b_i = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk_en = 1'b1;

    @(negedge clk);
    chk("reset_in_ready", int'(in_ready), 1);
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_prod", int'(prod), 0);

    // Largest product and latency: first out_valid in the cycle after edge T+5.
    send(16, 16);
    wait_result(p, lat);
    chk("16x16_prod", p, 256);
    chk("16x16_residue", p % 17, 1);
    chk("16x16_edges_to_valid", lat - 1, 5);

    send(0, 13);
    wait_result(p, lat);
    chk("0x13_prod", p, 0);
    send(13, 0);
    wait_result(p, lat);
    chk("13x0_prod", p, 0);

    send(20, 3);
    wait_result(p, lat);
    chk("20x3_prod", p, 9);
    send(31, 31);
    wait_result(p, lat);
    chk("31x31_prod", p, 196);
    chk("31x31_residue", p % 17, 9);

    // Backpressure: DONE held for 10 cycles, then one out_ready pulse.
    out_ready = 1'b0;
    send(7, 5);
    repeat (5) @(posedge clk);
    #1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || prod !== 9'd35 || in_ready !== 1'b0) bad++;
    end
    chk("7x5_hold_violations", bad, 0);
    chk("7x5_prod", int'(prod), 35);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("7x5_in_ready_after", int'(in_ready), 1);
    chk("7x5_out_valid_after", int'(out_valid), 0);
    out_ready = 1'b1;

    // Reset during the third MUL cycle discards the operation.
    send(9, 9);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_mid_in_ready", int'(in_ready), 1);
    chk("rst_mid_prod", int'(prod), 0);
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) bad++;
    end
    chk("rst_mid_no_valid", bad, 0);
    send(2, 3);
    wait_result(p, lat);
    chk("2x3_prod", p, 6);

    // Streaming: in_valid held high across all 1024 operand pairs.
    bad = 0;
    n_res = 0;
    last_acc = 0;
    in_valid = 1'b1;
    for (int x = 0; x < 32; x++) begin
      for (int y = 0; y < 32; y++) begin
        a_i = 5'(x);
        b_i = 5'(y);
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
          @(negedge clk);
          if (in_ready) ok = 1'b1;
        end
        @(posedge clk);
        #1;
        if (!ok) chk("stream_accept_timeout", 0, 1);
        if ((x != 0 || y != 0) && (cyc - last_acc) != 7) bad++;
        last_acc = cyc;
        if (x == 31 && y == 31) in_valid = 1'b0;
        wait_result(p, lat);
        if (p >= 0) n_res++;
        chk("stream_residue", p % 17, ((x % 17) * (y % 17)) % 17);
      end
    end
    chk("stream_results", n_res, 1024);
    chk("stream_gap_violations", bad, 0);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
